selftrigger_peak_detector: RTL



---
 rtl/selftrigger_peak_detector_pkg.sv | 18 +
 rtl/selftrigger_peak_detector_if.sv | 34 +++
 rtl/selftrigger_peak_detector_holdoff_counter.sv | 35 +++
 rtl/selftrigger_peak_detector.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/selftrigger_peak_detector_pkg.sv
// Shared types and defaults for the threshold self-trigger stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package selftrigger_pkg;

  localparam int SAMPLE_W        = 16;
  localparam int HOLDOFF_LEN_DEF = 256;
  localparam int MAX_WIDTH_DEF   = 1024;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ABOVE   = 2'd1,
    HOLDOFF = 2'd2
  } st_state_e;

endpackage

// File: rtl/selftrigger_peak_detector_if.sv
// Sample stream, trigger configuration and trigger/peak report bundle.
// Latency: n/a (wires only).
// Backpressure: none; enable qualifies every sample, reports are one-cycle pulses.
// master: drives enable, x, threshold, hysteresis; observes the reports.
// slave : the detector; consumes the stream and drives trigger, peak_valid,
//         peak_value, peak_time, overflow, busy.
interface selftrigger_peak_detector_if #(
  parameter int CNT_W = 16
);
  import selftrigger_pkg::*;

  logic                enable;
  sample_t             x;
  sample_t             threshold;
  logic [SAMPLE_W-1:0] hysteresis;

  logic                trigger;
  logic                peak_valid;
  sample_t             peak_value;
  logic [CNT_W-1:0]    peak_time;
  logic                overflow;
  logic                busy;

  modport master (
    output enable, x, threshold, hysteresis,
    input  trigger, peak_valid, peak_value, peak_time, overflow, busy
  );

  modport slave (
    input  enable, x, threshold, hysteresis,
    output trigger, peak_valid, peak_value, peak_time, overflow, busy
  );

endinterface

// File: rtl/selftrigger_peak_detector_holdoff_counter.sv
// Dead-time counter: load LEN, count down one per enabled sample, flag the last one.
// Latency: done is combinational from the count register.
// Backpressure: none; dec simply stalls when the chain enable is low.
// Ports: clk, rst_n (async, active-low), clear (sync), load, dec -> done.
module selftrigger_holdoff_counter #(
  parameter int LEN = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int W = $clog2(LEN + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(LEN);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // Asserted while the final dead-time sample is being consumed.
  assign done = (cnt == W'(1));

endmodule

// File: rtl/selftrigger_peak_detector.sv
// Threshold self-trigger: trigger pulse on upward crossing, peak/time-to-peak report, dead time.
// Latency: sample presented before edge k-1 is in x_r after k-1; trigger/peak_valid register at edge k.
// Backpressure: none; enable low freezes the input stage and returns the FSM to IDLE.
// Ports: clk, rst_n (async, active-low), bus (slave modport of selftrigger_peak_detector_if).
// Optional SELFTRIG_COUNTER_EN: adds cnt_clear (sync clear) and trig_count (saturating
// 32-bit count of trigger pulses).
module selftrigger_peak_detector
  import selftrigger_pkg::*;
#(
  parameter int HOLDOFF_LEN = HOLDOFF_LEN_DEF,
  parameter int MAX_WIDTH   = MAX_WIDTH_DEF,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef SELFTRIG_COUNTER_EN
  input  logic                          cnt_clear,
  output logic [31:0]                   trig_count,
`endif
  selftrigger_peak_detector_if.slave    bus
);

  st_state_e        state;
  sample_t          x_r;
  sample_t          x_d;
  sample_t          peak_value_int;
  logic [CNT_W-1:0] peak_time_int;
  logic [CNT_W-1:0] width;

  logic             trigger_q;
  logic             peak_valid_q;
  sample_t          peak_value_q;
  logic [CNT_W-1:0] peak_time_q;
  logic             overflow_q;

  // Input stage: only enabled samples advance the two-deep history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r <= '0;
      x_d <= '0;
    end else if (bus.enable) begin
      x_r <= bus.x;
      x_d <= x_r;
    end
  end

  logic crossing;
  assign crossing = (x_d < bus.threshold) && (x_r >= bus.threshold);

  // Exit level computed two bits wider so threshold minus a full-scale
  // hysteresis can never wrap.
  logic signed [SAMPLE_W+1:0] x_ext;
  logic signed [SAMPLE_W+1:0] thr_ext;
  logic signed [SAMPLE_W+1:0] hyst_ext;
  logic signed [SAMPLE_W+1:0] exit_lvl;
  logic                       below_exit;

  assign x_ext      = {{2{x_r[SAMPLE_W-1]}}, x_r};
  assign thr_ext    = {{2{bus.threshold[SAMPLE_W-1]}}, bus.threshold};
  assign hyst_ext   = {2'b00, bus.hysteresis};
  assign exit_lvl   = thr_ext - hyst_ext;
  assign below_exit = (x_ext < exit_lvl);

  // width holds the index of the last sample absorbed into the pulse
  // (crossing sample = 0), so width_inc is the index of the sample in x_r.
  logic [CNT_W-1:0] width_inc;
  logic             new_peak;
  sample_t          peak_value_nxt;
  logic [CNT_W-1:0] peak_time_nxt;
  logic             timeout;

  assign width_inc      = (width == '1) ? width : width + CNT_W'(1);
  assign new_peak       = (x_r > peak_value_int);  // strict: ties keep the earliest peak
  assign peak_value_nxt = new_peak ? x_r : peak_value_int;
  assign peak_time_nxt  = new_peak ? width_inc : peak_time_int;
  assign timeout        = (width_inc == CNT_W'(MAX_WIDTH - 1));

  logic ho_load;
  logic ho_dec;
  logic ho_done;

  assign ho_load = bus.enable && (state == ABOVE) && (below_exit || timeout);
  assign ho_dec  = bus.enable && (state == HOLDOFF);

  selftrigger_holdoff_counter #(
    .LEN (HOLDOFF_LEN)
  ) u_holdoff (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!bus.enable),
    .load  (ho_load),
    .dec   (ho_dec),
    .done  (ho_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      width          <= '0;
      peak_value_int <= '0;
      peak_time_int  <= '0;
      trigger_q      <= 1'b0;
      peak_valid_q   <= 1'b0;
      peak_value_q   <= '0;
      peak_time_q    <= '0;
      overflow_q     <= 1'b0;
    end else begin
      trigger_q    <= 1'b0;
      peak_valid_q <= 1'b0;
      if (!bus.enable) begin
        // Chain stalled: abandon any pulse in progress, keep last report.
        state         <= IDLE;
        width         <= '0;
        peak_time_int <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (crossing) begin
              state          <= ABOVE;
              trigger_q      <= 1'b1;
              peak_value_int <= x_r;
              peak_time_int  <= '0;
              width          <= '0;
            end
          end
          ABOVE: begin
            width          <= width_inc;
            peak_value_int <= peak_value_nxt;
            peak_time_int  <= peak_time_nxt;
            // Exit is checked first so a pulse ending on its last allowed
            // sample is reported as a normal pulse.
            if (below_exit || timeout) begin
              state        <= HOLDOFF;
              peak_valid_q <= 1'b1;
              overflow_q   <= !below_exit;
              peak_value_q <= peak_value_nxt;
              peak_time_q  <= peak_time_nxt;
            end
          end
          HOLDOFF: begin
            if (ho_done) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.trigger    = trigger_q;
  assign bus.peak_valid = peak_valid_q;
  assign bus.peak_value = peak_value_q;
  assign bus.peak_time  = peak_time_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = (state != IDLE);

`ifdef SELFTRIG_COUNTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_count <= '0;
    end else if (cnt_clear) begin
      trig_count <= '0;
    end else if (trigger_q && (trig_count != 32'hFFFF_FFFF)) begin
      trig_count <= trig_count + 32'd1;
    end
  end
`endif

endmodule
